pattern_frame_loader: RTL and testbench

//  Upstream stage of the dout/syn/clk serializer. Receives a byte stream (JTAG/UART bridge, valid/ready),

---
 rtl/pattern_frame_loader.sv | 215 +++++++++++++++++++++
 tb/tb_pattern_frame_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_frame_loader.sv
// Framed pattern upload parser: hunts for SYNC_BYTE, assembles a shadow pattern, commits atomically, fires trig.
// Optional trailing checksum byte is enabled by defining PFL_CHECKSUM_EN.
module pattern_frame_loader #(
  parameter int         MAX_BITS    = 1024,
  parameter int         TIMEOUT_CYC = 65535,
  parameter int         TRIG_CYCLES = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                busy,
  input  logic                trig_req,
  output logic [MAX_BITS-1:0] data_reg,
  output logic [9:0]          seq_length,
  output logic                trig,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [1:0]          err_code
);

  localparam int              SHW       = ((MAX_BITS + 7) / 8) * 8;
  localparam int              GW        = $clog2(TIMEOUT_CYC + 1);
  localparam int              TCW       = $clog2(TRIG_CYCLES + 1);
  localparam logic [9:0]      MAX_LEN   = 10'((MAX_BITS > 1023) ? 1023 : MAX_BITS);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0]   GAP_ONE   = GW'(1);
  localparam logic [TCW-1:0]  TRIG_N    = TCW'(TRIG_CYCLES);
  localparam logic [TCW-1:0]  TRIG_ONE  = TCW'(1);

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_HDR    = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_COMMIT = 3'd5,
    S_TRIG   = 3'd6
  } state_t;

  // Keeps only the bits of the current data byte that fall below the frame length.
  function automatic logic [7:0] tail_mask(input logic [10:0] rem);
    logic [7:0] m;
    m = 8'h00;
    for (int j = 0; j < 8; j++) begin
      m[j] = (rem > 11'(j));
    end
    return m;
  endfunction

  state_t           state_r;
  logic [9:0]       len_r;
  logic             len_ovf_r;
  logic             auto_trig_r;
  logic [7:0]       byte_idx_r;
  logic [GW-1:0]    gap_r;
  logic [TCW-1:0]   trig_cnt_r;
  logic [SHW-1:0]   shadow_r;
`ifdef PFL_CHECKSUM_EN
  logic [7:0]       csum_r;
`endif

  logic             ready_s;
  logic             accept_s;
  logic [9:0]       len_s;
  logic [7:0]       n_bytes_s;
  logic [10:0]      rem_s;
  logic             last_byte_s;

  // Byte-accept handshake and frame-length bookkeeping.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      S_HUNT:                          ready_s = ~trig_req;
      S_HDR, S_LEN_LO, S_DATA, S_CSUM: ready_s = 1'b1;
      default:                         ready_s = 1'b0;
    endcase
    accept_s    = rx_valid & ready_s & ~rst;
    len_s       = {len_r[9:8], rx_data};
    n_bytes_s   = 8'((11'(len_r) + 11'd7) >> 3);
    rem_s       = 11'(len_r) - {byte_idx_r, 3'b000};
    last_byte_s = (byte_idx_r == (n_bytes_s - 8'd1));
  end

  assign rx_ready = ready_s & ~rst;

  // Frame parser, commit and trigger sequencer.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r     <= S_HUNT;
      data_reg    <= '0;
      seq_length  <= 10'd0;
      trig        <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      len_r       <= 10'd0;
      len_ovf_r   <= 1'b0;
      auto_trig_r <= 1'b0;
      byte_idx_r  <= 8'd0;
      gap_r       <= '0;
      trig_cnt_r  <= '0;
      shadow_r    <= '0;
`ifdef PFL_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        S_HUNT: begin
          gap_r <= '0;
          if (trig_req && !busy && (seq_length != 10'd0)) begin
            state_r    <= S_TRIG;
            trig_cnt_r <= '0;
          end else if (accept_s && (rx_data == SYNC_BYTE)) begin
            state_r <= S_HDR;
          end
        end
        S_HDR, S_LEN_LO, S_DATA, S_CSUM: begin
          if (accept_s) begin
            gap_r <= '0;
            case (state_r)
              S_HDR: begin
                auto_trig_r <= rx_data[7];
                // Nonzero reserved header bits encode a length beyond the 10-bit field.
                len_ovf_r   <= |rx_data[6:2];
                len_r       <= {rx_data[1:0], 8'h00};
`ifdef PFL_CHECKSUM_EN
                csum_r      <= rx_data;
`endif
                state_r     <= S_LEN_LO;
              end
              S_LEN_LO: begin
                if (len_ovf_r || (len_s == 10'd0) || (len_s > MAX_LEN)) begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd1;
                  state_r   <= S_HUNT;
                end else begin
                  len_r      <= len_s;
                  shadow_r   <= '0;
                  byte_idx_r <= 8'd0;
`ifdef PFL_CHECKSUM_EN
                  csum_r     <= csum_r ^ rx_data;
`endif
                  state_r    <= S_DATA;
                end
              end
              S_DATA: begin
                for (int b = 0; b < SHW / 8; b++) begin
                  if (8'(b) == byte_idx_r) begin
                    shadow_r[8*b +: 8] <= rx_data & tail_mask(rem_s);
                  end
                end
                byte_idx_r <= byte_idx_r + 8'd1;
`ifdef PFL_CHECKSUM_EN
                csum_r <= csum_r ^ rx_data;
                if (last_byte_s) begin
                  state_r <= S_CSUM;
                end
`else
                if (last_byte_s) begin
                  state_r <= S_COMMIT;
                end
`endif
              end
              S_CSUM: begin
`ifdef PFL_CHECKSUM_EN
                if (rx_data == csum_r) begin
                  state_r <= S_COMMIT;
                end else begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd3;
                  state_r   <= S_HUNT;
                end
`else
                state_r <= S_COMMIT;
`endif
              end
              default: state_r <= S_HUNT;
            endcase
          end else if (gap_r == GAP_LAST) begin
            frame_err <= 1'b1;
            err_code  <= 2'd2;
            state_r   <= S_HUNT;
          end else begin
            gap_r <= gap_r + GAP_ONE;
          end
        end
        S_COMMIT: begin
          if (!busy) begin
            data_reg   <= shadow_r[MAX_BITS-1:0];
            seq_length <= len_r;
            frame_ok   <= 1'b1;
            trig_cnt_r <= '0;
            state_r    <= auto_trig_r ? S_TRIG : S_HUNT;
          end
        end
        S_TRIG: begin
          if (trig_cnt_r != TRIG_N) begin
            trig       <= 1'b1;
            trig_cnt_r <= trig_cnt_r + TRIG_ONE;
          end else begin
            trig    <= 1'b0;
            state_r <= S_HUNT;
          end
        end
        default: state_r <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_frame_loader.sv
// Scoreboard bench for pattern_frame_loader: expected commits/aborts are queued as frames are driven.
module tb_pattern_frame_loader;

  localparam int         MAX_BITS    = 1024;
  localparam int         TIMEOUT     = 300;
  localparam int         TRIG_CYCLES = 4;
  localparam logic [7:0] SYNC        = 8'hA5;

  typedef struct {
    bit            is_ok;
    logic [1:0]    code;
    logic [9:0]    len;
    logic [1023:0] data;
  } exp_t;

  logic                clk_in;
  logic                rst;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                busy;
  logic                trig_req;
  logic [MAX_BITS-1:0] data_reg;
  logic [9:0]          seq_length;
  logic                trig;
  logic                frame_ok;
  logic                frame_err;
  logic [1:0]          err_code;

  int            n_checks = 0;
  int            n_fail   = 0;
  exp_t          sb_q[$];
  exp_t          mon_e;
  logic [7:0]    pay_q[$];
  logic [1023:0] last_data = '0;
  logic [9:0]    last_len  = 10'd0;

  pattern_frame_loader #(
    .MAX_BITS   (MAX_BITS),
    .TIMEOUT_CYC(TIMEOUT),
    .TRIG_CYCLES(TRIG_CYCLES),
    .SYNC_BYTE  (SYNC)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .trig_req  (trig_req),
    .data_reg  (data_reg),
    .seq_length(seq_length),
    .trig      (trig),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (n >= 100) check_eq("send_stall", 512'(n), 512'd0);
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] lo, input bit bad_csum,
                            input logic [1:0] code);
    exp_t       e;
    logic [7:0] cs;
    logic [7:0] bb;
    int         len;
    len    = int'({hdr[1:0], lo});
    e.is_ok = (code == 2'd0);
    e.code  = code;
    e.len   = 10'(len);
    e.data  = '0;
    if (code == 2'd0) begin
      for (int i = 0; i < len; i++) begin
        bb = pay_q[i / 8];
        e.data[i] = bb[i % 8];
      end
    end
    sb_q.push_back(e);
    send_byte(SYNC);
    send_byte(hdr);
    send_byte(lo);
    cs = hdr ^ lo;
    foreach (pay_q[i]) begin
      send_byte(pay_q[i]);
      cs = cs ^ pay_q[i];
    end
`ifdef PFL_CHECKSUM_EN
    if (code != 2'd1) send_byte(bad_csum ? (cs ^ 8'h01) : cs);
`else
    if (bad_csum) cs = ~cs;
`endif
  endtask

  task automatic expect_trig(input string tag, input int lat);
    int n = 0;
    int w = 0;
    while (trig !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    check_eq({tag, "_lat"}, 512'(n), 512'(lat));
    while (trig === 1'b1 && w < 40) begin
      w++;
      @(negedge clk_in);
    end
    check_eq({tag, "_width"}, 512'(w), 512'(TRIG_CYCLES));
  endtask

  task automatic expect_no_trig(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk_in);
      seen = seen | trig;
    end
    check_eq(tag, 512'(seen), 512'd0);
  endtask

  // Scoreboard consumer: every frame_ok/frame_err pulse pops one expectation.
  always @(negedge clk_in) begin
    if (!rst && (frame_ok || frame_err)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 512'({frame_ok, frame_err}), 512'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("sb_kind", 512'({frame_ok, frame_err}), mon_e.is_ok ? 512'd2 : 512'd1);
        if (mon_e.is_ok) begin
          last_data = mon_e.data;
          last_len  = mon_e.len;
        end else begin
          check_eq("err_code", 512'(err_code), 512'(mon_e.code));
        end
        check_eq("seq_length", 512'(seq_length), 512'(last_len));
        check_eq("data_lo", data_reg[511:0], last_data[511:0]);
        check_eq("data_hi", data_reg[1023:512], last_data[1023:512]);
      end
    end
  end

  initial begin
    logic any_ready, any_ok, changed, any_trig;
    int   n;
    exp_t e;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; busy = 1'b0; trig_req = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_ready", 512'(rx_ready), 512'd0);
    check_eq("rst_data", data_reg[511:0], 512'd0);
    check_eq("rst_len", 512'(seq_length), 512'd0);
    check_eq("rst_flags", 512'({trig, frame_ok, frame_err, err_code}), 512'd0);
    @(negedge clk_in);
    rst = 1'b0;
    @(posedge clk_in); #1;
    check_eq("idle_ready", 512'(rx_ready), 512'd1);
    send_byte(8'h33);
    send_byte(8'h5A);

    // T1: len=451, auto trig, idle serializer
    pay_q.delete();
    repeat (57) pay_q.push_back(8'h5A);
    send_frame(8'h81, 8'hC3, 1'b0, 2'd0);
    @(posedge clk_in); #1;
    check_eq("t1_ok_lat", 512'(frame_ok), 512'd1);
    expect_trig("t1_trig", 2);

    // T2: same shape, serializer busy for 20 cycles after the last byte
    pay_q.delete();
    repeat (57) pay_q.push_back(8'h3C);
    busy = 1'b1;
    send_frame(8'h81, 8'hC3, 1'b0, 2'd0);
    any_ready = 1'b0; any_ok = 1'b0; changed = 1'b0;
    repeat (20) begin
      @(negedge clk_in);
      any_ready = any_ready | rx_ready;
      any_ok    = any_ok | frame_ok;
      changed   = changed | (data_reg !== last_data);
    end
    check_eq("t2_ready_low", 512'(any_ready), 512'd0);
    check_eq("t2_no_early_ok", 512'(any_ok), 512'd0);
    check_eq("t2_data_held", 512'(changed), 512'd0);
    busy = 1'b0;
    @(posedge clk_in); #1;
    check_eq("t2_ok", 512'(frame_ok), 512'd1);
    expect_trig("t2_trig", 2);

    // T6a: re-fire request held off while busy
    @(posedge clk_in); #1;
    busy = 1'b1; trig_req = 1'b1;
    any_trig = 1'b0;
    repeat (10) begin
      @(negedge clk_in);
      any_trig = any_trig | trig;
    end
    check_eq("t6_busy_no_trig", 512'(any_trig), 512'd0);
    check_eq("t6_ready_low", 512'(rx_ready), 512'd0);
    busy = 1'b0;
    @(posedge clk_in); #1;
    trig_req = 1'b0;
    expect_trig("t6_trig", 2);

    // T3: bad lengths
    pay_q.delete();
    send_frame(8'h00, 8'h00, 1'b0, 2'd1);
    check_eq("t3_hunt_ready", 512'(rx_ready), 512'd1);
    send_frame(8'h04, 8'h05, 1'b0, 2'd1);

`ifdef PFL_CHECKSUM_EN
    // T4: corrupted checksum
    pay_q.delete();
    pay_q.push_back(8'h12);
    pay_q.push_back(8'h34);
    send_frame(8'h80, 8'h10, 1'b1, 2'd3);
    expect_no_trig("t4_no_trig", 10);
`endif

    // T5: idle gap after three data bytes
    e.is_ok = 1'b0; e.code = 2'd2; e.len = 10'd0; e.data = '0;
    sb_q.push_back(e);
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h28);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    n = 0;
    while (!frame_err && n < 2 * TIMEOUT) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("t5_gap_min", 512'(n >= TIMEOUT), 512'd1);
    check_eq("t5_gap_max", 512'(n <= TIMEOUT + 2), 512'd1);
    pay_q.delete();
    pay_q.push_back(8'hAB);
    pay_q.push_back(8'hCD);
    send_frame(8'h00, 8'h0C, 1'b0, 2'd0);
    expect_no_trig("t5_no_trig", 10);

    // Boundaries: partial last byte with SYNC as data, full 1023-bit length, single bit
    pay_q.delete();
    pay_q.push_back(8'hA5);
    pay_q.push_back(8'hFF);
    send_frame(8'h80, 8'h09, 1'b0, 2'd0);
    expect_trig("len9_trig", 3);
    pay_q.delete();
    repeat (128) pay_q.push_back(8'($urandom));
    send_frame(8'h03, 8'hFF, 1'b0, 2'd0);
    expect_no_trig("len1023_no_trig", 6);
    pay_q.delete();
    pay_q.push_back(8'hFF);
    send_frame(8'h00, 8'h01, 1'b0, 2'd0);
    repeat (4) @(negedge clk_in);
    check_eq("sb_drain", 512'(sb_q.size()), 512'd0);

    // T6b: reset in the middle of a trigger pulse
    trig_req = 1'b1;
    n = 0;
    while (trig !== 1'b1 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    trig_req = 1'b0;
    check_eq("t6b_trig_up", 512'(trig), 512'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6b_trig_async", 512'(trig), 512'd0);
    check_eq("t6b_ready", 512'(rx_ready), 512'd0);
    check_eq("t6b_data", data_reg[511:0], 512'd0);
    check_eq("t6b_len_err", 512'({seq_length, err_code}), 512'd0);
    @(negedge clk_in);
    rst = 1'b0;
    repeat (2) @(posedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
